// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned FRAME_BITS       = 10;
  localparam int unsigned CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud timer: reloadable down-counter that pulses bit_tick for one cycle per bit period.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  assign bit_tick = en && (cnt == 16'd0);

  // clear preloads a full period so the first tick lands exactly one bit after frame start
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt <= 16'd0;
    end else if (clear) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == 16'd0) cnt <= RELOAD;
      else              cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a two-step host interface: load a byte, then command the send.
//   state | meaning
//   IDLE  | line high; accepts loads, starts a frame when a loaded byte is commanded
//   START | start bit (low) for one bit period
//   DATA  | payload bits, LSB first, one bit period each
//   STOP  | stop bit (high) for one bit period; busy drops when it ends
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] IN_Data,
  input  logic                 byte_ready,
  input  logic                 tx_byte,
  output logic                 Tx,
  output logic                 tx_busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [DATA_BITS-1:0] hold, hold_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic                 loaded, loaded_nxt;
  logic                 tx_nxt, busy_nxt;
  logic                 baud_clr, bit_tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (baud_clr),
    .en       (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hold    <= '0;
      shift   <= '0;
      bit_idx <= '0;
      loaded  <= 1'b0;
      Tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      shift   <= shift_nxt;
      bit_idx <= bit_idx_nxt;
      loaded  <= loaded_nxt;
      Tx      <= tx_nxt;
      tx_busy <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    loaded_nxt  = loaded;
    tx_nxt      = Tx;
    busy_nxt    = tx_busy;
    baud_clr    = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (byte_ready) begin
          hold_nxt   = IN_Data;
          loaded_nxt = 1'b1;
        end
        // the send consumes the load, so a held tx_byte cannot retransmit
        if (loaded && tx_byte) begin
          state_nxt  = START;
          shift_nxt  = hold;
          loaded_nxt = 1'b0;
          tx_nxt     = 1'b0;
          busy_nxt   = 1'b1;
          baud_clr   = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_IDX) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shift_nxt   = shift >> 1;
            tx_nxt      = shift[1];
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a slot-based frame model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int FRAME_CYC = FRAME_BITS * N;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IN_Data = 8'h00;
  logic       byte_ready = 1'b0;
  logic       tx_byte = 1'b0;
  logic       Tx;
  logic       tx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .IN_Data    (IN_Data),
    .byte_ready (byte_ready),
    .tx_byte    (tx_byte),
    .Tx         (Tx),
    .tx_busy    (tx_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Line level k cycles into a frame: slot 0 start, slots 1..8 data LSB first, slot 9 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int slot;
    slot = k / N;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_eq({tag, "_tx"}, Tx, 1'b1);
      check_eq({tag, "_busy"}, tx_busy, 1'b0);
      step();
    end
  endtask

  // junk_at: frame cycle where a load is attempted mid-frame (-1 none).
  // abort_at: frame cycle where reset is asserted (-1 none).
  task automatic run_frame(input logic [7:0] d, input logic [7:0] junk,
                           input int junk_at, input int abort_at);
    tx_byte    = 1'b0;
    byte_ready = 1'b1;
    IN_Data    = 8'($urandom);
    step();
    IN_Data = d;
    repeat ($urandom_range(1, 8)) begin
      check_eq("load_busy", tx_busy, 1'b0);
      step();
    end
    byte_ready = 1'b0;
    tx_byte    = 1'b1;
    IN_Data    = 8'($urandom);
    step();
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check_eq("abort_tx", Tx, 1'b1);
        check_eq("abort_busy", tx_busy, 1'b0);
        step();
        reset = 1'b1;
        idle_check("post_abort", 20);
        tx_byte = 1'b0;
        return;
      end
      check_eq("frame_tx", Tx, frame_bit(d, k));
      check_eq("frame_busy", tx_busy, 1'b1);
      if (k == junk_at) begin
        byte_ready = 1'b1;
        IN_Data    = junk;
      end else if (k == junk_at + 2) begin
        byte_ready = 1'b0;
      end else begin
        IN_Data = 8'($urandom);
      end
      step();
    end
    byte_ready = 1'b0;
    idle_check("no_retx", 3 * N + 10);
    tx_byte = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    check_eq("rst_tx", Tx, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    reset = 1'b1;
    idle_check("idle", 20);

    tx_byte = 1'b1;
    idle_check("no_load", 20);
    tx_byte = 1'b0;

    run_frame(8'hB2, 8'h00, -1, -1);
    run_frame(8'h55, 8'hFF, 2 * N + 1, -1);
    for (int i = 0; i < 12; i++) begin
      run_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, FRAME_CYC - 5)), -1);
    end
    run_frame(8'hB2, 8'h00, -1, 4 * N + 1);
    run_frame(8'h3C, 8'h00, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 serial transmitter with a two-step host interface. The host first loads a parallel byte into a holding register with byte_ready. It then commands transmission with tx_byte. The block sits between a processor-side peripheral bus and the off-chip TX pin, and reports activity on tx_busy.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (baud divisor); legal range 2..65535.
DATA_BITS, 8, payload bits per frame; only 8 is required.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
IN_Data  input  8  parallel byte to transmit.
byte_ready  input  1  level; load IN_Data into the holding register.
tx_byte  input  1  level; start transmitting the held byte.
Tx  output  1  serial line, idle high; registered output.
tx_busy  output  1  high while a frame is on the line; registered output.

Behaviour:
- Reset (reset=0, asynchronous):
  - Tx=1, tx_busy=0, state=IDLE, holding register=0, loaded flag=0, baud and bit counters=0.
  - Reset asserted mid-frame aborts the frame immediately: Tx returns to 1 with no stop bit.
- Load rule:
  - At a rising edge with byte_ready=1 and state=IDLE, the holding register captures IN_Data and loaded is set to 1.
  - Repeated loads while idle overwrite the register; the last value wins.
  - byte_ready is ignored while tx_busy=1.
- Start rule:
  - At a rising edge with state=IDLE, loaded=1 and tx_byte=1: state goes to START, Tx=0, tx_busy=1, loaded cleared. The shift register takes the held byte.
  - The start bit is visible the cycle after the sampling edge.
  - tx_byte with loaded=0 is ignored.
  - byte_ready=1 and tx_byte=1 on the same edge with loaded=0: the load happens on that edge and transmission starts on the next edge if tx_byte is still high.
- States:
  - IDLE: Tx=1.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: Tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE and drop tx_busy to 0 on that same edge.
- Frame timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles; tx_busy is high for exactly that many cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit index counts 0..7.
- Back-to-back:
  - A level-held tx_byte does not retransmit. A new byte_ready load is required, accepted no earlier than the first IDLE cycle.
  - The earliest next start bit is therefore two edges after tx_busy falls.
- IN_Data changes after loading have no effect on the frame in flight.

Decomposition:
- Package uart_pkg:
  - state enum uart_state_e {IDLE, START, DATA, STOP}.
  - localparam FRAME_BITS=10.
  - Default CLKS_PER_BIT.
- One natural sub-module, uart_baud_gen:
  - Parameterised down-counter producing a one-cycle bit_tick.
  - Restarted (cleared) on frame start.
- The FSM, holding register and shift register stay in uart_tx.

Test Plan:
1. Reset then idle: reset low 2 cycles, then high 20 cycles, no strobes -> Tx=1 and tx_busy=0 throughout.
2. Basic frame, CLKS_PER_BIT=4: IN_Data=8'hB2, byte_ready=1 for 10 cycles, then tx_byte=1 and byte_ready=0 -> one edge later Tx sequence per 4-cycle bit is 0 | 0,1,0,0,1,1,0,1 | 1. tx_busy is high for exactly 40 cycles, then Tx stays 1.
3. No retransmit: hold tx_byte=1 for 100 cycles after scenario 2 -> only one frame, tx_busy low after cycle 40.
4. tx_byte without load: after reset, tx_byte=1 for 20 cycles with byte_ready=0 -> Tx=1, tx_busy=0.
5. Load ignored while busy: start 8'h55, then byte_ready with IN_Data=8'hFF mid-frame -> data bits are 1,0,1,0,1,0,1,0. A later tx_byte without a new load sends nothing.
6. Reset mid-frame: assert reset during bit 3 of 8'hB2 -> Tx=1 and tx_busy=0 asynchronously. After release, tx_byte alone sends nothing (loaded cleared).
